ks_string_ctrl: RTL and testbench

//  Per-string sequencer for the Karplus-Strong delay line. Accepts pluck requests
//  (pitch delay, amplitude, decay), drives the delay line with a noise burst, then

---
 rtl/ks_string_ctrl_pkg.sv | 35 +++
 rtl/ks_string_ctrl_if.sv | 27 ++
 rtl/ks_string_ctrl_noise_lfsr.sv | 25 ++
 rtl/ks_string_ctrl.sv | 143 ++++++++++++++
 tb/tb_ks_string_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_string_ctrl_pkg.sv
// ks_string_ctrl_pkg
//   Shared constants, state type and helpers for the Karplus-Strong string
//   sequencer. Imported by the noise LFSR and the string controller.
//   No ports.
package ks_string_ctrl_pkg;

  // Largest legal delay; must equal the delay line's depth minus one.
  localparam logic [9:0]         MAXDELAY   = 10'd1000;
  localparam logic [9:0]         MINDELAY   = 10'd2;
  // Loop gain (x/256) used once the string has been damped.
  localparam logic [7:0]         DAMP_DECAY = 8'd128;
  // Magnitude below which a sample counts as silent.
  localparam logic signed [23:0] SIL_THRESH = 24'sd64;
  // Nonzero reset value and Galois tap mask for x^24+x^23+x^22+x^17+1.
  localparam logic [23:0]        LFSR_SEED  = 24'h5EED01;
  localparam logic [23:0]        LFSR_TAPS  = 24'hE10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    RING   = 2'd2,
    DAMP   = 2'd3
  } state_t;

  // Limit a requested string length to what the delay line can hold.
  function automatic logic [9:0] clamp_delay(input logic [9:0] d);
    if (d < MINDELAY)
      return MINDELAY;
    else if (d > MAXDELAY)
      return MAXDELAY;
    else
      return d;
  endfunction

endpackage

// File: rtl/ks_string_ctrl_if.sv
// ks_string_ctrl_if
//   Pluck-request channel between the note/voice logic and one string.
//   note_valid  : pluck request
//   note_ready  : request accepted when note_valid & note_ready
//   note_delay  : string length in samples (pitch)
//   note_amp    : excitation amplitude, unsigned
//   note_decay  : loop gain x/256 while ringing
//   note_off    : one-cycle pulse that damps the string
//   master = voice logic side, slave = string controller side.
interface ks_string_ctrl_if;
  logic        note_valid;
  logic        note_ready;
  logic [9:0]  note_delay;
  logic [22:0] note_amp;
  logic [7:0]  note_decay;
  logic        note_off;

  modport master (
    output note_valid, note_delay, note_amp, note_decay, note_off,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_delay, note_amp, note_decay, note_off,
    output note_ready
  );
endinterface

// File: rtl/ks_string_ctrl_noise_lfsr.sv
// ks_string_ctrl_noise_lfsr
//   24-bit Galois LFSR (x^24+x^23+x^22+x^17+1) supplying excitation noise.
//   Advances on every frame clock, whatever the string is doing.
//   lrck  in   frame clock
//   rst_n in   synchronous active-low reset, loads SEED
//   lfsr  out  current 24-bit LFSR state
module ks_string_ctrl_noise_lfsr
  import ks_string_ctrl_pkg::*;
#(
  parameter logic [23:0] SEED = LFSR_SEED
) (
  input  logic        lrck,
  input  logic        rst_n,
  output logic [23:0] lfsr
);

  // Right-shifting Galois form: the bit falling out folds back into the taps.
  always_ff @(posedge lrck) begin
    if (!rst_n)
      lfsr <= SEED;
    else
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 24'd0);
  end

endmodule

// File: rtl/ks_string_ctrl.sv
// ks_string_ctrl
//   Per-string sequencer for a Karplus-Strong delay line. A pluck fills the
//   line with `delay` noise samples, then the loop is closed through a 2-tap
//   averaging lowpass with gain. note_off switches to a fixed damping gain,
//   and a full line's worth of near-silent samples returns the string to idle.
//   lrck       in   frame clock
//   rst_n      in   synchronous active-low reset
//   note       if   pluck request channel (slave side)
//   dl_out     in   signed sample returned by the delay line
//   dl_in      out  signed sample written to the delay line (registered)
//   dl_delay   out  latched delay setting for the delay line
//   sample_out out  string output, identical to dl_in
//   busy       out  string is not idle
module ks_string_ctrl
  import ks_string_ctrl_pkg::*;
(
  input  logic               lrck,
  input  logic               rst_n,
  ks_string_ctrl_if.slave    note,
  input  logic signed [23:0] dl_out,
  output logic signed [23:0] dl_in,
  output logic [9:0]         dl_delay,
  output logic signed [23:0] sample_out,
  output logic               busy
);

  state_t             state;
  logic [22:0]        amp;
  logic [7:0]         decay;
  logic [9:0]         cnt;
  logic [9:0]         sil;
  logic signed [23:0] prev;
  logic               off_pend;
  logic [23:0]        lfsr;

  logic               accept;
  logic signed [24:0] sum;
  logic signed [23:0] avg;
  logic [7:0]         gain;
  logic signed [32:0] avg_x;
  logic signed [32:0] gain_x;
  logic signed [32:0] prod;
  logic signed [23:0] filt;
  logic signed [23:0] noise;
  logic               silent;
  logic [9:0]         sil_inc;
  logic               unused_bits;

  ks_string_ctrl_noise_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .lrck  (lrck),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // A new pluck can interrupt a ringing or damped string, never a burst.
  assign note.note_ready = (state != EXCITE);
  assign accept          = note.note_valid & note.note_ready;
  assign busy            = (state != IDLE);
  assign sample_out      = dl_in;

  // Loop filter: average of the returning sample and the previous one,
  // floored by the arithmetic shift, then scaled by gain/256 (also floored).
  // The average always fits 24 bits and the gain is below one, so the
  // product's bits [31:8] hold the whole result without saturation.
  assign sum    = {dl_out[23], dl_out} + {prev[23], prev};
  assign avg    = sum[24:1];
  assign gain   = (state == DAMP) ? DAMP_DECAY : decay;
  assign avg_x  = {{9{avg[23]}}, avg};
  assign gain_x = {25'd0, gain};
  assign prod   = avg_x * gain_x;
  assign filt   = prod[31:8];

  assign noise   = lfsr[0] ? $signed({1'b0, amp}) : -$signed({1'b0, amp});
  assign silent  = (filt < SIL_THRESH) && (filt > -SIL_THRESH);
  assign sil_inc = sil + 10'd1;

  assign unused_bits = ^{sum[0], prod[32], prod[7:0], lfsr[23:1]};

  // Sequencer: burst of noise, then feedback through the loop filter.
  // A pluck accepted in the same cycle overrides whatever the current state
  // decided about its next state and counters, which also drops a coincident
  // note_off. The current state still produces this cycle's sample.
  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      state    <= IDLE;
      dl_in    <= '0;
      dl_delay <= MINDELAY;
      amp      <= '0;
      decay    <= '0;
      cnt      <= '0;
      sil      <= '0;
      prev     <= '0;
      off_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dl_in <= '0;
        end
        EXCITE: begin
          dl_in <= noise;
          cnt   <= cnt + 10'd1;
          if (note.note_off)
            off_pend <= 1'b1;
          // A note_off on the final burst sample still counts.
          if (cnt == dl_delay - 10'd1) begin
            state <= (off_pend || note.note_off) ? DAMP : RING;
            sil   <= '0;
          end
        end
        RING, DAMP: begin
          prev <= dl_out;
          if (state == RING && note.note_off) begin
            dl_in <= filt;
            state <= DAMP;
            sil   <= '0;
          end else if (silent && sil_inc == dl_delay && !accept) begin
            dl_in <= '0;
            state <= IDLE;
            sil   <= '0;
          end else begin
            dl_in <= filt;
            sil   <= silent ? sil_inc : 10'd0;
          end
        end
        default: begin
          dl_in <= '0;
        end
      endcase

      if (accept) begin
        state    <= EXCITE;
        dl_delay <= clamp_delay(note.note_delay);
        amp      <= note.note_amp;
        decay    <= note.note_decay;
        cnt      <= '0;
        sil      <= '0;
        prev     <= '0;
        off_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ks_string_ctrl.sv
// tb_ks_string_ctrl
//   Self-checking bench for ks_string_ctrl. Stimulus tasks drive one frame at
//   a time, step a behavioural string model and queue the expected outputs;
//   a monitor pops and compares after every rising frame clock.
module tb_ks_string_ctrl;

  logic               lrck;
  logic               rst_n;
  logic signed [23:0] dl_out;
  logic signed [23:0] dl_in;
  logic [9:0]         dl_delay;
  logic signed [23:0] sample_out;
  logic               busy;

  ks_string_ctrl_if note_if();

  ks_string_ctrl dut (
    .lrck       (lrck),
    .rst_n      (rst_n),
    .note       (note_if),
    .dl_out     (dl_out),
    .dl_in      (dl_in),
    .dl_delay   (dl_delay),
    .sample_out (sample_out),
    .busy       (busy)
  );

  // Frame clock.
  initial begin
    lrck = 1'b0;
    forever #5 lrck = ~lrck;
  end

  typedef struct {
    int dl_in;
    int dl_delay;
    bit busy;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Behavioural string model: plain integers, floor division, a mode number.
  localparam int M_IDLE   = 0;
  localparam int M_EXCITE = 1;
  localparam int M_RING   = 2;
  localparam int M_DAMP   = 3;

  int          m_mode;
  int          m_out;
  int          m_dly;
  int          m_amp;
  int          m_decay;
  int          m_prev;
  int          m_n;
  int          m_quiet;
  bit          m_pend;
  int unsigned m_lfsr;
  int unsigned m_mask;

  function automatic int fdiv(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d) != 0 && x < 0)
      q = q - 1;
    return q;
  endfunction

  function automatic int clampd(input int d);
    if (d < 2)
      return 2;
    if (d > 1000)
      return 1000;
    return d;
  endfunction

  // One frame of the model using the inputs currently driven.
  function void model_step();
    int y;
    int g;
    int dout;
    bit acc;
    bit off;
    int nxt;
    dout = dl_out;
    off  = note_if.note_off;
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_out   = 0;
      m_dly   = 2;
      m_amp   = 0;
      m_decay = 0;
      m_prev  = 0;
      m_n     = 0;
      m_quiet = 0;
      m_pend  = 0;
      m_lfsr  = 32'h5EED01;
      return;
    end
    acc = note_if.note_valid && (m_mode != M_EXCITE);
    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      m_out = 0;
    end else if (m_mode == M_EXCITE) begin
      m_out = ((m_lfsr & 1) != 0) ? m_amp : -m_amp;
      m_n   = m_n + 1;
      if (off)
        m_pend = 1;
      if (m_n == m_dly) begin
        nxt     = m_pend ? M_DAMP : M_RING;
        m_quiet = 0;
      end
    end else begin
      g      = (m_mode == M_DAMP) ? 128 : m_decay;
      y      = fdiv(fdiv(dout + m_prev, 2) * g, 256);
      m_prev = dout;
      if (m_mode == M_RING && off) begin
        nxt     = M_DAMP;
        m_quiet = 0;
        m_out   = y;
      end else if (y < 64 && y > -64 && m_quiet + 1 == m_dly && !acc) begin
        nxt     = M_IDLE;
        m_quiet = 0;
        m_out   = 0;
      end else begin
        m_out   = y;
        m_quiet = (y < 64 && y > -64) ? m_quiet + 1 : 0;
      end
    end
    if (acc) begin
      m_dly   = clampd(int'(note_if.note_delay));
      m_amp   = int'(note_if.note_amp);
      m_decay = int'(note_if.note_decay);
      m_n     = 0;
      m_pend  = 0;
      m_prev  = 0;
      m_quiet = 0;
      nxt     = M_EXCITE;
    end
    m_mode = nxt;
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? m_mask : 0);
  endfunction

  function automatic int rnd_dout(input int kind);
    int v;
    if (kind == 0) begin
      v = int'($urandom & 32'h00FFFFFF);
      if (v >= 32'h800000)
        v = v - 32'h1000000;
    end else if (kind == 1) begin
      v = int'($urandom_range(0, 126)) - 63;
    end else begin
      v = int'($urandom_range(0, 180)) - 90;
    end
    return v;
  endfunction

  task automatic applyStimulus(input bit rstn, input bit valid, input bit off,
                               input int nd, input int na, input int ndec,
                               input int dout);
    @(negedge lrck);
    rst_n               = rstn;
    note_if.note_valid  = valid;
    note_if.note_off    = off;
    note_if.note_delay  = 10'(nd);
    note_if.note_amp    = 23'(na);
    note_if.note_decay  = 8'(ndec);
    dl_out              = 24'(dout);
    model_step();
    exp_q.push_back('{m_out, m_dly, m_mode != M_IDLE, m_mode != M_EXCITE});
  endtask

  task automatic resetFor(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, rnd_dout(0));
  endtask

  task automatic runFor(input int n, input int kind);
    repeat (n) applyStimulus(1, 0, 0, 0, 0, 0, rnd_dout(kind));
  endtask

  task automatic pluck(input int nd, input int na, input int ndec);
    applyStimulus(1, 1, 0, nd, na, ndec, rnd_dout(0));
  endtask

  task automatic noteOff(input int kind);
    applyStimulus(1, 0, 1, 0, 0, 0, rnd_dout(kind));
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    cmp("dl_in",      int'(dl_in),              e.dl_in);
    cmp("sample_out", int'(sample_out),         e.dl_in);
    cmp("dl_delay",   int'(dl_delay),           e.dl_delay);
    cmp("busy",       int'(busy),               int'(e.busy));
    cmp("note_ready", int'(note_if.note_ready), int'(e.ready));
  endtask

  // Monitor: registered outputs settle just after the rising edge.
  always @(posedge lrck) begin
    #1;
    cyc++;
    if (exp_q.size() > 0)
      checkOutput(exp_q.pop_front());
  end

  initial begin
    bit v;
    bit o;
    int d;
    m_mask = (32'd1 << (24 - 1)) | (32'd1 << (23 - 1)) |
             (32'd1 << (22 - 1)) | (32'd1 << (17 - 1));
    rst_n              = 1'b0;
    note_if.note_valid = 1'b0;
    note_if.note_off   = 1'b0;
    note_if.note_delay = '0;
    note_if.note_amp   = '0;
    note_if.note_decay = '0;
    dl_out             = '0;

    $display("[TB] reset and idle");
    resetFor(3);
    runFor(3, 0);

    $display("[TB] pluck delay=100, then reset mid-ring");
    pluck(100, 32'h100000, 255);
    runFor(160, 0);
    resetFor(3);
    runFor(2, 0);

    $display("[TB] delay clamping");
    pluck(0, 32'h1234, 200);
    runFor(22, 0);
    pluck(1023, 32'h5678, 200);
    runFor(1010, 0);
    resetFor(2);

    $display("[TB] loop filter directed values");
    pluck(4, 32'h1000, 128);
    runFor(4, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1000);
    applyStimulus(1, 0, 0, 0, 0, 0, -3001);
    runFor(10, 0);

    $display("[TB] note_off during excitation, note_off with retrigger");
    pluck(50, 32'h40000, 240);
    runFor(10, 0);
    noteOff(0);
    runFor(70, 0);
    pluck(8, 32'h40000, 250);
    runFor(13, 0);
    applyStimulus(1, 1, 1, 8, 32'h30000, 200, rnd_dout(0));
    runFor(28, 0);

    $display("[TB] silence return and retrigger while damped");
    pluck(20, 32'h20, 255);
    runFor(45, 1);
    pluck(20, 32'h20, 255);
    runFor(25, 1);
    noteOff(1);
    runFor(3, 1);
    pluck(30, 32'h20, 100);
    runFor(75, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 39) == 0);
      o = ($urandom_range(0, 29) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023))
                                      : int'($urandom_range(0, 40));
      applyStimulus(1, v, o, d, int'($urandom_range(0, 32'h7FFFFF)),
                    int'($urandom_range(0, 255)),
                    rnd_dout(int'($urandom_range(0, 2))));
    end

    @(posedge lrck);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
